// File: rtl/decrement_sequencer.sv
// Loadable down-counter with prescaler, pause, abort and optional auto-reload.
// Three-state control: IDLE accepts a start, RUN counts down, DONE pulses once.
module decrement_sequencer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_valid,
    input  logic [3:0] start_value,
    output logic       start_ready,
    input  logic       pause,
    input  logic       abort,
    input  logic       auto_reload,
    output logic [3:0] count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seqState_t;

    localparam logic [3:0] PRESC_MAX = 4'(PRESCALE - 1);

    seqState_t  state, stateNext;
    logic [3:0] countReg, countNext;
    logic [3:0] presc, prescNext;
    logic [3:0] reloadReg, reloadNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            countReg  <= '0;
            presc     <= '0;
            reloadReg <= '0;
        end else begin
            state     <= stateNext;
            countReg  <= countNext;
            presc     <= prescNext;
            reloadReg <= reloadNext;
        end
    end

    always_comb begin
        stateNext  = state;
        countNext  = countReg;
        prescNext  = presc;
        reloadNext = reloadReg;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    countNext  = start_value;
                    reloadNext = start_value;
                    prescNext  = '0;
                    stateNext  = (start_value != 4'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                // abort outranks pause and terminal count
                if (abort) begin
                    stateNext = IDLE;
                    countNext = '0;
                    prescNext = '0;
                end else if (!pause) begin
                    if (presc == PRESC_MAX) begin
                        prescNext = '0;
                        countNext = countReg + 4'b1111;
                        if (countReg == 4'd1) begin
                            stateNext = DONE;
                        end
                    end else begin
                        prescNext = presc + 4'd1;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    stateNext = IDLE;
                    countNext = '0;
                    prescNext = '0;
                end else if (auto_reload && (reloadReg != 4'd0)) begin
                    stateNext = RUN;
                    countNext = reloadReg;
                    prescNext = '0;
                end else begin
                    stateNext = IDLE;
                    countNext = '0;
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
                prescNext = '0;
            end
        endcase
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign count       = countReg;

endmodule
